manchester_frame_sync: RTL and testbench

- Downstream neighbour of the Manchester decoder. Consumes its 0..2 decoded bits per cycle, hunts for a sync word, then packs payload bits into bytes.
- Emits a fixed-length frame as a push-only byte stream with a last-byte marker. Aborts the frame on an idle timeout.
- Sits between the Manchester decoder and the packet/FIFO logic; there is no backpressure, because the recovered bit stream cannot stall.

---
 rtl/manchester_frame_sync.sv | 167 ++++++++++++++++
 tb/tb_manchester_frame_sync.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/manchester_frame_sync.sv
// Sync-word hunter and byte packer behind the Manchester decoder; emits fixed-length frames.
// Optional frame statistics outputs are enabled with `define FRAME_SYNC_STATS_EN.
module manchester_frame_sync #(
  parameter logic [7:0] SYNC_WORD    = 8'hD5,
  parameter int         FRAME_LEN    = 4,
  parameter int         IDLE_TIMEOUT = 64
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [1:0] decoded_bits,
  input  logic [1:0] num_decoded_bits,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  output logic       locked,
  output logic       frame_abort,
  output logic       in_error
`ifdef FRAME_SYNC_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_aborted
`endif
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [16:0] TIMEOUT  = 17'(IDLE_TIMEOUT);

  state_t      state_reg, state_next;
  logic [7:0]  hunt_reg, hunt_next;
  logic [3:0]  fill_reg, fill_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  byte_cnt_reg, byte_cnt_next;
  logic [15:0] idle_reg, idle_next;
  logic [7:0]  tdata_reg, tdata_next;
  logic        tvalid_reg, tvalid_next;
  logic        tlast_reg, tlast_next;
  logic        abort_reg, abort_next;
  logic        error_reg, error_next;
  logic [1:0]  n_bits;
  logic        bit_val;

  always_comb begin
    state_next    = state_reg;
    hunt_next     = hunt_reg;
    fill_next     = fill_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    idle_next     = 16'd0;
    tdata_next    = tdata_reg;
    tvalid_next   = 1'b0;
    tlast_next    = 1'b0;
    abort_next    = 1'b0;
    error_next    = (num_decoded_bits == 2'd3);
    n_bits        = (num_decoded_bits == 2'd3) ? 2'd0 : num_decoded_bits;
    bit_val       = 1'b0;

    // Bits are walked in arrival order so a state change on bit [0] applies to bit [1].
    for (int i = 0; i < 2; i++) begin
      if (n_bits > 2'(i)) begin
        bit_val = decoded_bits[i];
        if (state_next == HUNT) begin
          hunt_next = {hunt_next[6:0], bit_val};
          if (fill_next != 4'd8) fill_next = fill_next + 4'd1;
          if (fill_next == 4'd8 && hunt_next == SYNC_WORD) begin
            state_next    = LOCKED;
            hunt_next     = 8'd0;
            fill_next     = 4'd0;
            shift_next    = 8'd0;
            bit_cnt_next  = 3'd0;
            byte_cnt_next = 8'd0;
          end
        end else begin
          shift_next = {shift_next[6:0], bit_val};
          if (bit_cnt_next == 3'd7) begin
            bit_cnt_next = 3'd0;
            tdata_next   = shift_next;
            tvalid_next  = 1'b1;
            if (byte_cnt_next == LAST_IDX) begin
              tlast_next    = 1'b1;
              state_next    = HUNT;
              byte_cnt_next = 8'd0;
              hunt_next     = 8'd0;
              fill_next     = 4'd0;
            end else begin
              byte_cnt_next = byte_cnt_next + 8'd1;
            end
          end else begin
            bit_cnt_next = bit_cnt_next + 3'd1;
          end
        end
      end
    end

    // Idle cycles only count while locked; any consumed bit restarts the count.
    if (state_reg == LOCKED && n_bits == 2'd0) begin
      if ({1'b0, idle_reg} + 17'd1 == TIMEOUT) begin
        abort_next    = 1'b1;
        state_next    = HUNT;
        shift_next    = 8'd0;
        bit_cnt_next  = 3'd0;
        byte_cnt_next = 8'd0;
        hunt_next     = 8'd0;
        fill_next     = 4'd0;
      end else begin
        idle_next = idle_reg + 16'd1;
      end
    end
  end

`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] frames_ok_reg, frames_aborted_reg;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg    <= HUNT;
      hunt_reg     <= 8'd0;
      fill_reg     <= 4'd0;
      shift_reg    <= 8'd0;
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= 8'd0;
      idle_reg     <= 16'd0;
      tdata_reg    <= 8'd0;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      abort_reg    <= 1'b0;
      error_reg    <= 1'b0;
`ifdef FRAME_SYNC_STATS_EN
      frames_ok_reg      <= 16'd0;
      frames_aborted_reg <= 16'd0;
`endif
    end else begin
      state_reg    <= state_next;
      hunt_reg     <= hunt_next;
      fill_reg     <= fill_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      idle_reg     <= idle_next;
      tdata_reg    <= tdata_next;
      tvalid_reg   <= tvalid_next;
      tlast_reg    <= tlast_next;
      abort_reg    <= abort_next;
      error_reg    <= error_next;
`ifdef FRAME_SYNC_STATS_EN
      if (tlast_next) frames_ok_reg <= frames_ok_reg + 16'd1;
      if (abort_next) frames_aborted_reg <= frames_aborted_reg + 16'd1;
`endif
    end
  end

  assign m_tdata     = tdata_reg;
  assign m_tvalid    = tvalid_reg;
  assign m_tlast     = tlast_reg;
  assign locked      = (state_reg == LOCKED);
  assign frame_abort = abort_reg;
  assign in_error    = error_reg;
`ifdef FRAME_SYNC_STATS_EN
  assign frames_ok      = frames_ok_reg;
  assign frames_aborted = frames_aborted_reg;
`endif

endmodule

// File: tb/tb_manchester_frame_sync.sv
// Directed bench for manchester_frame_sync: sync hunt, byte packing, timeout, error and reset cases.
module tb_manchester_frame_sync;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [1:0] decoded_bits = 2'd0;
  logic [1:0] num_decoded_bits = 2'd0;
  logic [7:0] m_tdata, z_tdata;
  logic       m_tvalid, m_tlast, locked, frame_abort, in_error;
  logic       z_tvalid, z_tlast, z_locked, z_abort, z_error;
`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] frames_ok, frames_aborted, z_ok, z_aborted;
`endif

  always #5 clk = ~clk;

  manchester_frame_sync dut (
    .aclk(clk), .areset(areset), .decoded_bits(decoded_bits), .num_decoded_bits(num_decoded_bits),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .locked(locked),
    .frame_abort(frame_abort), .in_error(in_error)
`ifdef FRAME_SYNC_STATS_EN
    , .frames_ok(frames_ok), .frames_aborted(frames_aborted)
`endif
  );

  // Zero sync word instance for the reset-fill case.
  manchester_frame_sync #(.SYNC_WORD(8'h00)) dut_zero (
    .aclk(clk), .areset(areset), .decoded_bits(decoded_bits), .num_decoded_bits(num_decoded_bits),
    .m_tdata(z_tdata), .m_tvalid(z_tvalid), .m_tlast(z_tlast), .locked(z_locked),
    .frame_abort(z_abort), .in_error(z_error)
`ifdef FRAME_SYNC_STATS_EN
    , .frames_ok(z_ok), .frames_aborted(z_aborted)
`endif
  );

  int checks = 0;
  int errors = 0;
  int n_last = 0, n_abort = 0, n_err = 0, n_overlap = 0;
  logic [8:0] rxq[$];
  bit bitq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step(input logic [1:0] db, input logic [1:0] n, input logic rst);
    @(negedge clk);
    decoded_bits = db;
    num_decoded_bits = n;
    areset = rst;
    @(posedge clk);
    #1;
    if (m_tvalid) rxq.push_back({m_tlast, m_tdata});
    if (m_tvalid && m_tlast) n_last++;
    if (frame_abort) n_abort++;
    if (in_error) n_err++;
    if (m_tvalid && frame_abort) n_overlap++;
  endtask

  task automatic do_reset();
    step(2'd0, 2'd0, 1'b1);
    step(2'd0, 2'd0, 1'b1);
    rxq.delete();
    bitq.delete();
    n_last = 0;
    n_abort = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bitq.push_back(b[i]);
  endtask

  task automatic drain_n(input int per, input int nsteps);
    logic b0, b1;
    for (int s = 0; s < nsteps; s++) begin
      if (bitq.size() == 0) break;
      b0 = bitq.pop_front();
      if (per == 2 && bitq.size() > 0) begin
        b1 = bitq.pop_front();
        step({b1, b0}, 2'd2, 1'b0);
      end else begin
        step({1'b0, b0}, 2'd1, 1'b0);
      end
    end
  endtask

  logic [7:0] payload [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  initial begin
    // Reset state
    do_reset();
    check("rst_tdata", 32'(m_tdata), 32'h0);
    check("rst_tvalid", 32'(m_tvalid), 32'h0);
    check("rst_tlast", 32'(m_tlast), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_abort", 32'(frame_abort), 32'h0);
    check("rst_error", 32'(in_error), 32'h0);

    // Frame at 1 bit per cycle
    push_byte(8'hD5);
    drain_n(1, 7);
    check("t1_locked_7", 32'(locked), 32'h0);
    drain_n(1, 1);
    check("t1_locked_8", 32'(locked), 32'h1);
    for (int i = 0; i < 4; i++) push_byte(payload[i]);
    drain_n(1, 32);
    check("t1_last_tvalid", 32'(m_tvalid), 32'h1);
    check("t1_last_tlast", 32'(m_tlast), 32'h1);
    check("t1_last_tdata", 32'(m_tdata), 32'h78);
    check("t1_unlocked", 32'(locked), 32'h0);
    check("t1_nbytes", 32'(rxq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_byte%0d", i), 32'(rxq[i]), 32'({(i == 3), payload[i]}));

    // Frame at 2 bits per cycle, sync ends on bit [0]
    do_reset();
    bitq.push_back(1'b0);
    push_byte(8'hD5);
    for (int i = 0; i < 4; i++) push_byte(payload[i]);
    bitq.push_back(1'b0);
    drain_n(2, 4);
    check("t2_locked_early", 32'(locked), 32'h0);
    drain_n(2, 1);
    check("t2_locked", 32'(locked), 32'h1);
    drain_n(2, 16);
    check("t2_last_tlast", 32'(m_tlast), 32'h1);
    check("t2_unlocked", 32'(locked), 32'h0);
    check("t2_nbytes", 32'(rxq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_byte%0d", i), 32'(rxq[i]), 32'({(i == 3), payload[i]}));

    // Zero sync word: lock only when the fill counter reaches 8
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'd0, 2'd1, 1'b0);
      check($sformatf("t3_zlocked_%0d", i), 32'(z_locked), 32'((i == 7)));
    end

    // Idle timeout after one full byte and a partial one
    do_reset();
    push_byte(8'hD5);
    push_byte(8'hAB);
    bitq.push_back(1'b1); bitq.push_back(1'b1); bitq.push_back(1'b0); bitq.push_back(1'b0);
    drain_n(1, 20);
    check("t4_locked", 32'(locked), 32'h1);
    for (int i = 0; i < 63; i++) step(2'd0, 2'd0, 1'b0);
    check("t4_abort_63", 32'(n_abort), 32'd0);
    check("t4_locked_63", 32'(locked), 32'h1);
    step(2'd0, 2'd0, 1'b0);
    check("t4_abort_64", 32'(frame_abort), 32'h1);
    check("t4_unlocked", 32'(locked), 32'h0);
    step(2'd0, 2'd0, 1'b0);
    check("t4_abort_pulse", 32'(frame_abort), 32'h0);
    check("t4_nabort", 32'(n_abort), 32'd1);
    check("t4_nlast", 32'(n_last), 32'd0);
    check("t4_nbytes", 32'(rxq.size()), 32'd1);
    check("t4_byte0", 32'(rxq[0]), 32'h0AB);

    // Illegal bit count mid-payload
    do_reset();
    push_byte(8'hD5);
    bitq.push_back(1'b1); bitq.push_back(1'b0); bitq.push_back(1'b1); bitq.push_back(1'b0);
    drain_n(1, 12);
    step(2'b11, 2'd3, 1'b0);
    check("t5_error", 32'(in_error), 32'h1);
    check("t5_locked", 32'(locked), 32'h1);
    step(2'b00, 2'd1, 1'b0);
    check("t5_error_pulse", 32'(in_error), 32'h0);
    bitq.push_back(1'b1); bitq.push_back(1'b0); bitq.push_back(1'b1);
    drain_n(1, 3);
    check("t5_nbytes", 32'(rxq.size()), 32'd1);
    check("t5_byte0", 32'(rxq[0]), 32'h0A5);

    // Reset during byte 2
    do_reset();
    push_byte(8'hD5);
    push_byte(8'h11);
    bitq.push_back(1'b0); bitq.push_back(1'b0); bitq.push_back(1'b1);
    drain_n(1, 19);
    check("t6_nbytes_pre", 32'(rxq.size()), 32'd1);
    step(2'b01, 2'd1, 1'b1);
    check("t6_rst_locked", 32'(locked), 32'h0);
    check("t6_rst_tvalid", 32'(m_tvalid), 32'h0);
    check("t6_rst_tdata", 32'(m_tdata), 32'h0);
    check("t6_rst_abort", 32'(frame_abort), 32'h0);
    push_byte(8'h22);
    push_byte(8'h33);
    drain_n(1, 16);
    check("t6_no_bytes", 32'(rxq.size()), 32'd1);
    check("t6_no_lock", 32'(locked), 32'h0);
    push_byte(8'hD5);
    push_byte(8'h44);
    drain_n(1, 16);
    check("t6_nbytes_post", 32'(rxq.size()), 32'd2);
    check("t6_byte_post", 32'(rxq[1]), 32'h044);
    check("t6_nabort", 32'(n_abort), 32'd0);

    check("err_pulses", 32'(n_err), 32'd1);
    check("valid_abort_overlap", 32'(n_overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
